// File: rtl/lru_pkg.sv
// Shared types and helpers for the least-recently-granted arbiter.
package lru_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] req_id_t;

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  function automatic logic [N_REQ-1:0] onehot(input req_id_t id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: pulses tick for one clk every TICK_DIV cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;

  assign tick = (div_q == DivW'(TICK_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/lru_arbiter.sv
// Four-way arbiter granting the least-recently-granted requester, with a
// hold timer that forces release after HOLD_TICKS ticks.
module lru_arbiter
  import lru_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout,
  output logic [7:0]       order_o
);

  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

  state_e                 state_q, state_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  req_id_t [N_REQ-1:0]    order_q, order_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  req_id_t                owner_q, owner_d;
  logic                   timeout_q, timeout_d;
  logic                   tick;
  logic                   found;
  req_id_t                win_pos;
  req_id_t                winner;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Entry 0 is the LRU slot, so the first requesting entry wins.
  always_comb begin
    found   = 1'b0;
    win_pos = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[order_q[i]]) begin
        found   = 1'b1;
        win_pos = req_id_t'(i);
      end
    end
    winner = order_q[win_pos];
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    order_d   = order_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = onehot(winner);
          owner_d = winner;
          hold_d  = '0;
          for (int i = 0; i < N_REQ - 1; i++) begin
            if (req_id_t'(i) >= win_pos) begin
              order_d[i] = order_q[i+1];
            end
          end
          order_d[N_REQ-1] = winner;
        end
      end
      StGrant: begin
        // A voluntary drop takes priority over a coincident timeout.
        if (!req[owner_q]) begin
          state_d = StRelease;
          gnt_d   = '0;
          owner_d = '0;
          hold_d  = '0;
        end else if (tick && (hold_q == HoldW'(HOLD_TICKS - 1))) begin
          state_d   = StRelease;
          gnt_d     = '0;
          owner_d   = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        order_q[i] <= req_id_t'(i);
      end
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      order_q   <= order_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == StGrant);
  assign timeout = timeout_q;
  assign order_o = order_q;

endmodule

// File: tb/tb_lru_arbiter.sv
// Directed scoreboard bench for lru_arbiter (HOLD_TICKS=3, TICK_DIV=1).
module tb_lru_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic [7:0] order_o;

  typedef struct {
    int unsigned cyc;
    int unsigned step;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int unsigned cycle_cnt = 0;
  int unsigned step_no   = 0;
  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  logic [15:0] act;

  lru_arbiter #(
    .HOLD_TICKS(3),
    .TICK_DIV  (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .timeout(timeout),
    .order_o(order_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: outputs after each edge are compared at the following negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == cycle_cnt) begin
      cur = exp_q.pop_front();
      act = {gnt, owner, busy, timeout, order_o};
      n_checks++;
      if (act === cur.val) begin
        n_pass++;
      end else begin
        $display("FAIL step%0d gnt/owner/busy/timeout/order: got %b/%0d/%b/%b/%h want %b/%0d/%b/%b/%h",
                 cur.step, act[15:12], act[11:10], act[9], act[8], act[7:0],
                 cur.val[15:12], cur.val[11:10], cur.val[9], cur.val[8], cur.val[7:0]);
      end
    end
  end

  // Drive one cycle of inputs; expectation is for outputs after the next edge.
  task automatic step(input logic rst_v, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] o, input logic b, input logic t,
                      input logic [7:0] ord);
    exp_t e;
    @(posedge clk);
    #2;
    rst = rst_v;
    req = r;
    step_no++;
    e.cyc  = cycle_cnt + 1;
    e.step = step_no;
    e.val  = {g, o, b, t, ord};
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    // Reset
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hE4);
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hE4);
    // Round-robin through LRU: 0,1,2,3,0
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h39);
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h39);
    step(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h39);
    step(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h39);
    step(1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h4E);
    step(1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h4E);
    step(1'b1, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h4E);
    step(1'b1, 4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h4E);
    step(1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h93);
    step(1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h93);
    step(1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h93);
    step(1'b1, 4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h93);
    step(1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hE4);
    step(1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hE4);
    step(1'b1, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hE4);
    step(1'b1, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hE4);
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h39);
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h39);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h39);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h39);
    // Held request times out after 3 ticks, re-granted after 2-cycle gap
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h8D);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h8D);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h8D);
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1, 8'h8D);
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h8D);
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h8D);
    step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h8D);
    step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h8D);
    // Grant to 1; req[3] ignored; drop coincides with timeout edge
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h63);
    step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h63);
    step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h63);
    step(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h63);
    step(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h63);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hD8);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hD8);
    // Reset mid-grant, then arbitrate from reset order
    step(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'hE4);
    step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h78);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h78);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h78);

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
